uart_rx_frame: RTL and testbench

//  Parametrised UART receiver, successor to the fixed 8-bit frame receiver.
//  - Oversamples async serial line rx_serial; LSB-first data bits.
//  - Configurable data width, parity mode and stop-bit count.
//  - Delivers each word on a valid/ready handshake with per-word parity/frame/break status and an overrun pulse.
//  - Sits between the pad-side serial input and the UART host/FIFO interface.

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_rx_sync.sv | 32 +++
 rtl/uart_rx_frame.sv | 200 ++++++++++++++++++++
 tb/tb_uart_rx_frame.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and parity-sense constants.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_HIGH
    } rx_state_t;

    // Parity sense: value XORed into the data/parity reduction that must come out 0.
    localparam logic PARITY_EVEN = 1'b0;
    localparam logic PARITY_ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous serial line, with a falling-edge
// detector on the synchronised value. All flops reset to 1 (idle line).
module uart_rx_sync (
    input  logic clk,
    input  logic reset_n,
    input  logic rx_serial,
    output logic rxs,
    output logic rxs_fall
);

    logic sync_q1;
    logic sync_q2;
    logic rxs_prev;

    // Synchronise the pad input and keep one extra stage for edge detection.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q1  <= 1'b1;
            sync_q2  <= 1'b1;
            rxs_prev <= 1'b1;
        end else begin
            // NOTE: non-blocking assignments make every flop sample the pre-edge value, giving a real 2-stage chain.
            sync_q1  <= rx_serial;
            sync_q2  <= sync_q1;
            rxs_prev <= sync_q2;
        end
    end

    assign rxs      = sync_q2;
    assign rxs_fall = rxs_prev & ~sync_q2;

endmodule

// File: rtl/uart_rx_frame.sv
// Parametrised UART receiver: oversampled, LSB-first, optional parity, 1 or 2
// stop bits, valid/ready delivery with per-word status and overrun pulse.
module uart_rx_frame #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8,
    parameter int PARITY_EN    = 1,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 rx_serial,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun_err,
    output logic                 busy
);

    import uart_pkg::rx_state_t;
    import uart_pkg::RX_IDLE;
    import uart_pkg::RX_START;
    import uart_pkg::RX_DATA;
    import uart_pkg::RX_PARITY;
    import uart_pkg::RX_STOP;
    import uart_pkg::RX_WAIT_HIGH;

    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [BAUD_W-1:0] BAUD_MID  = BAUD_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    localparam logic PAR_EN       = (PARITY_EN != 0);
    localparam logic PARITY_SENSE = (PARITY_ODD != 0) ? uart_pkg::PARITY_ODD : uart_pkg::PARITY_EVEN;

    rx_state_t state, state_nxt;

    logic                 rxs;
    logic                 rxs_fall;
    logic [BAUD_W-1:0]    baud_cnt;
    logic [BIT_W-1:0]     bit_cnt;
    logic [DATA_BITS-1:0] data_sr;
    logic                 par_bit;
    logic                 frame_err_acc;
    logic                 stop_one_acc;

    logic mid_tick;
    logic full_tick;
    logic sample_tick;
    logic frame_done;
    logic frame_err_now;
    logic parity_err_now;
    logic break_now;

    uart_rx_sync u_sync (
        .clk       (clk),
        .reset_n   (reset_n),
        .rx_serial (rx_serial),
        .rxs       (rxs),
        .rxs_fall  (rxs_fall)
    );

    assign mid_tick  = (baud_cnt == BAUD_MID);
    assign full_tick = (baud_cnt == BAUD_LAST);

    // Status of the frame as seen at the final stop-bit sample (includes that sample).
    assign frame_err_now  = frame_err_acc | ~rxs;
    assign parity_err_now = PAR_EN & ((^data_sr) ^ par_bit ^ PARITY_SENSE);
    assign break_now      = (data_sr == '0) & ~par_bit & ~stop_one_acc & ~rxs;

    assign busy = (state != RX_IDLE);

    // State register.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= RX_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state decode, bit-sample strobe and frame-completion strobe.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
        state_nxt   = state;
        sample_tick = 1'b0;
        frame_done  = 1'b0;
        case (state)
            RX_IDLE: begin
                if (rxs_fall) state_nxt = RX_START;
            end
            RX_START: begin
                sample_tick = mid_tick;
                // A start bit that is high again at mid-bit was a glitch.
                if (mid_tick) state_nxt = rxs ? RX_IDLE : RX_DATA;
            end
            RX_DATA: begin
                sample_tick = full_tick;
                if (full_tick && bit_cnt == BIT_LAST) state_nxt = PAR_EN ? RX_PARITY : RX_STOP;
            end
            RX_PARITY: begin
                sample_tick = full_tick;
                if (full_tick) state_nxt = RX_STOP;
            end
            RX_STOP: begin
                sample_tick = full_tick;
                if (full_tick && bit_cnt == STOP_LAST) begin
                    frame_done = 1'b1;
                    // Completing at mid stop bit re-arms start detection half a bit early.
                    state_nxt  = frame_err_now ? RX_WAIT_HIGH : RX_IDLE;
                end
            end
            RX_WAIT_HIGH: begin
                // A held-low line (break) must return high before a new start counts.
                if (rxs) state_nxt = RX_IDLE;
            end
            default: state_nxt = RX_IDLE;
        endcase
    end

    // Baud/bit counters and the per-frame shift and status accumulators.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            baud_cnt      <= '0;
            bit_cnt       <= '0;
            data_sr       <= '0;
            par_bit       <= 1'b0;
            frame_err_acc <= 1'b0;
            stop_one_acc  <= 1'b0;
        end else begin
            if (state == RX_IDLE || state == RX_WAIT_HIGH || sample_tick) begin
                baud_cnt <= '0;
            end else begin
                baud_cnt <= baud_cnt + BAUD_W'(1);
            end

            case (state)
                RX_START: begin
                    bit_cnt       <= '0;
                    par_bit       <= 1'b0;
                    frame_err_acc <= 1'b0;
                    stop_one_acc  <= 1'b0;
                end
                RX_DATA: begin
                    if (full_tick) begin
                        // LSB arrives first, so shifting right leaves it in bit 0 after the last bit.
                        data_sr <= {rxs, data_sr[DATA_BITS-1:1]};
                        bit_cnt <= (bit_cnt == BIT_LAST) ? '0 : bit_cnt + BIT_W'(1);
                    end
                end
                RX_PARITY: begin
                    if (full_tick) par_bit <= rxs;
                end
                RX_STOP: begin
                    if (full_tick) begin
                        bit_cnt       <= bit_cnt + BIT_W'(1);
                        frame_err_acc <= frame_err_acc | ~rxs;
                        stop_one_acc  <= stop_one_acc | rxs;
                    end
                end
                default: ;
            endcase
        end
    end

    // Word delivery: load on completion if the holding slot is free (or being
    // emptied this cycle), otherwise drop the new word and pulse overrun.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_data     <= '0;
            rx_valid    <= 1'b0;
            parity_err  <= 1'b0;
            frame_err   <= 1'b0;
            break_det   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            overrun_err <= 1'b0;
            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data    <= data_sr;
                    rx_valid   <= 1'b1;
                    parity_err <= parity_err_now;
                    frame_err  <= frame_err_now;
                    break_det  <= break_now;
                end else begin
                    overrun_err <= 1'b1;
                end
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame: an 8E1 instance (defaults) and a 9N2 instance.
module tb_uart_rx_frame;

    localparam int BIT_T = 16;

    typedef struct {
        logic [8:0] data;
        logic       perr;
        logic       ferr;
        logic       brk;
    } word_t;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       perr;
        logic       ferr;
        logic       brk;
    } vec_t;

    logic       clk;
    logic       reset_n;

    logic       a_line, a_ready, a_valid, a_perr, a_ferr, a_brk, a_ovr, a_busy;
    logic [7:0] a_data;
    logic       b_line, b_ready, b_valid, b_perr, b_ferr, b_brk, b_ovr, b_busy;
    logic [8:0] b_data;

    int n_vec;
    int n_miss;
    int a_ovr_cnt;
    int a_valid_cycles;
    word_t qa[$];
    word_t qb[$];

    uart_rx_frame dut_a (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_serial   (a_line),
        .rx_data     (a_data),
        .rx_valid    (a_valid),
        .rx_ready    (a_ready),
        .parity_err  (a_perr),
        .frame_err   (a_ferr),
        .break_det   (a_brk),
        .overrun_err (a_ovr),
        .busy        (a_busy)
    );

    uart_rx_frame #(
        .CLKS_PER_BIT (16),
        .DATA_BITS    (9),
        .PARITY_EN    (0),
        .PARITY_ODD   (0),
        .STOP_BITS    (2)
    ) dut_b (
        .clk         (clk),
        .reset_n     (reset_n),
        .rx_serial   (b_line),
        .rx_data     (b_data),
        .rx_valid    (b_valid),
        .rx_ready    (b_ready),
        .parity_err  (b_perr),
        .frame_err   (b_ferr),
        .break_det   (b_brk),
        .overrun_err (b_ovr),
        .busy        (b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: sampled 2 time units after each rising edge; records accepted words.
    always @(posedge clk) begin
        #2;
        if (a_valid && a_ready) qa.push_back('{data: {1'b0, a_data}, perr: a_perr, ferr: a_ferr, brk: a_brk});
        if (b_valid && b_ready) qb.push_back('{data: b_data, perr: b_perr, ferr: b_ferr, brk: b_brk});
        if (a_ovr) a_ovr_cnt++;
        if (a_valid) a_valid_cycles++;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    function automatic logic [15:0] frame_a(input logic [7:0] d, input logic par, input logic stop);
        return {5'b0, stop, par, d, 1'b0};
    endfunction

    function automatic logic [15:0] frame_b(input logic [8:0] d, input logic stop1, input logic stop2);
        return {4'b0, stop2, stop1, d, 1'b0};
    endfunction

    task automatic send_bits(input bit to_b, input logic [15:0] bits, input int nbits);
        for (int i = 0; i < nbits; i++) begin
            if (to_b) b_line = bits[i];
            else      a_line = bits[i];
            tick(BIT_T);
        end
        if (to_b) b_line = 1'b1;
        else      a_line = 1'b1;
    endtask

    task automatic expect_a(input string tag, input logic [8:0] d, input logic pe, input logic fe, input logic bk);
        word_t w;
        check({tag, " count"}, qa.size(), 1);
        if (qa.size() > 0) begin
            w = qa.pop_front();
            check({tag, " data"}, w.data, d);
            check({tag, " parity_err"}, w.perr, pe);
            check({tag, " frame_err"}, w.ferr, fe);
            check({tag, " break_det"}, w.brk, bk);
        end
        qa.delete();
    endtask

    task automatic expect_b(input string tag, input logic [8:0] d, input logic fe);
        word_t w;
        check({tag, " count"}, qb.size(), 1);
        if (qb.size() > 0) begin
            w = qb.pop_front();
            check({tag, " data"}, w.data, d);
            check({tag, " parity_err"}, w.perr, 1'b0);
            check({tag, " frame_err"}, w.ferr, fe);
            check({tag, " break_det"}, w.brk, 1'b0);
        end
        qb.delete();
    endtask

    initial begin
        vec_t vecs[6];
        int   k;

        // data, parity bit sent, stop bit sent, expected perr/ferr/brk
        vecs[0] = '{data: 8'hA5, par: 1'b0, stop: 1'b1, perr: 1'b0, ferr: 1'b0, brk: 1'b0};
        vecs[1] = '{data: 8'h3C, par: 1'b1, stop: 1'b1, perr: 1'b1, ferr: 1'b0, brk: 1'b0};
        vecs[2] = '{data: 8'hFF, par: 1'b0, stop: 1'b0, perr: 1'b0, ferr: 1'b1, brk: 1'b0};
        vecs[3] = '{data: 8'h00, par: 1'b0, stop: 1'b0, perr: 1'b0, ferr: 1'b1, brk: 1'b1};
        vecs[4] = '{data: 8'h01, par: 1'b1, stop: 1'b1, perr: 1'b0, ferr: 1'b0, brk: 1'b0};
        vecs[5] = '{data: 8'h80, par: 1'b0, stop: 1'b1, perr: 1'b1, ferr: 1'b0, brk: 1'b0};

        n_vec = 0;
        n_miss = 0;
        a_ovr_cnt = 0;
        a_valid_cycles = 0;
        reset_n = 1'b0;
        a_line = 1'b1;
        b_line = 1'b1;
        a_ready = 1'b1;
        b_ready = 1'b1;

        // Reset state.
        tick(3);
        check("reset a outputs", {a_valid, a_perr, a_ferr, a_brk, a_ovr, a_busy, a_data}, 0);
        check("reset b outputs", {b_valid, b_perr, b_ferr, b_brk, b_ovr, b_busy, b_data}, 0);
        reset_n = 1'b1;
        tick(5);

        // Delivery latency: rx_valid one clock after the stop-bit mid-sample.
        qa.delete();
        a_valid_cycles = 0;
        k = 0;
        fork
            send_bits(1'b0, frame_a(8'hA5, 1'b0, 1'b1), 11);
            begin
                while (a_valid !== 1'b1 && k < 400) begin
                    tick();
                    k++;
                end
            end
        join
        check("latency cycles to rx_valid", k, 171);
        tick(BIT_T);
        check("rx_valid high cycles", a_valid_cycles, 1);
        expect_a("latency word", 9'h0A5, 1'b0, 1'b0, 1'b0);

        // Table of single frames with rx_ready held high.
        for (int i = 0; i < 6; i++) begin
            qa.delete();
            send_bits(1'b0, frame_a(vecs[i].data, vecs[i].par, vecs[i].stop), 11);
            tick(2 * BIT_T);
            expect_a($sformatf("vec%0d", i), {1'b0, vecs[i].data}, vecs[i].perr, vecs[i].ferr, vecs[i].brk);
            check($sformatf("vec%0d busy idle", i), a_busy, 1'b0);
        end

        // Overrun: second word arrives while the first is still pending.
        qa.delete();
        a_ovr_cnt = 0;
        a_ready = 1'b0;
        send_bits(1'b0, frame_a(8'h11, 1'b0, 1'b1), 11);
        send_bits(1'b0, frame_a(8'h22, 1'b0, 1'b1), 11);
        tick(2 * BIT_T);
        check("overrun held valid", a_valid, 1'b1);
        check("overrun held data", a_data, 8'h11);
        check("overrun pulse count", a_ovr_cnt, 1);
        a_ready = 1'b1;
        tick();
        check("overrun valid drops", a_valid, 1'b0);
        expect_a("overrun accepted", 9'h011, 1'b0, 1'b0, 1'b0);

        // Break: line low for 20 bit times gives exactly one zero word.
        qa.delete();
        a_line = 1'b0;
        tick(20 * BIT_T);
        a_line = 1'b1;
        tick(4 * BIT_T);
        check("break busy cleared", a_busy, 1'b0);
        expect_a("break word", 9'h000, 1'b0, 1'b1, 1'b1);
        send_bits(1'b0, frame_a(8'h42, 1'b0, 1'b1), 11);
        tick(2 * BIT_T);
        expect_a("after break", 9'h042, 1'b0, 1'b0, 1'b0);

        // Glitch: 5-clock low pulse must not start a frame.
        qa.delete();
        a_line = 1'b0;
        tick(5);
        a_line = 1'b1;
        check("glitch busy during start", a_busy, 1'b1);
        tick(20);
        check("glitch busy returns 0", a_busy, 1'b0);
        tick(12 * BIT_T);
        check("glitch no word", qa.size(), 0);

        // Reset mid-DATA with a held word carrying a parity error.
        qa.delete();
        a_ready = 1'b0;
        send_bits(1'b0, frame_a(8'h3C, 1'b1, 1'b1), 11);
        tick(2 * BIT_T);
        check("pre-reset held flags", {a_valid, a_perr}, 2'b11);
        a_line = 1'b0;
        tick(BIT_T);
        a_line = 1'b0;
        tick(BIT_T);
        a_line = 1'b1;
        tick(BIT_T);
        check("pre-reset busy", a_busy, 1'b1);
        reset_n = 1'b0;
        tick(2);
        check("mid-frame reset outputs", {a_valid, a_perr, a_ferr, a_brk, a_ovr, a_busy, a_data}, 0);
        reset_n = 1'b1;
        tick(12 * BIT_T);
        check("partial frame discarded", {a_valid, a_busy}, 2'b00);
        check("partial frame no word", qa.size(), 0);
        a_ready = 1'b1;
        send_bits(1'b0, frame_a(8'h5A, 1'b0, 1'b1), 11);
        tick(2 * BIT_T);
        expect_a("post-reset word", 9'h05A, 1'b0, 1'b0, 1'b0);

        // 9N2 instance: clean all-ones word, then second stop bit low.
        qb.delete();
        send_bits(1'b1, frame_b(9'h1FF, 1'b1, 1'b1), 12);
        tick(2 * BIT_T);
        expect_b("9n2 0x1FF", 9'h1FF, 1'b0);
        send_bits(1'b1, frame_b(9'h0AA, 1'b1, 1'b0), 12);
        tick(2 * BIT_T);
        expect_b("9n2 stop2 low", 9'h0AA, 1'b1);
        send_bits(1'b1, frame_b(9'h155, 1'b1, 1'b1), 12);
        tick(2 * BIT_T);
        expect_b("9n2 after ferr", 9'h155, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
